ads1115_i2c_target: RTL and testbench

I2C target (slave) that emulates the ADS1115 register interface so that our ADS1115 I2C master logic can be exercised and verified on the board without a physical converter. The block watches the shared SCL/SDA lines and decodes START, address, pointer and data bytes. It implements the four 16-bit ADS1115 registers and drives SDA open-drain for ACKs and read data. The conversion value it returns comes from a parallel input, typically a counter or switches in the top level.

---
 rtl/ads1115_i2c_target.sv | 247 ++++++++++++++++++++++++
 tb/tb_ads1115_i2c_target.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1115_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : ads1115_i2c_target
// Description : I2C target that emulates the ADS1115 register map so that the
//               ADS1115 master logic can be exercised without a real
//               converter.
//               Pointer 00 : conversion register (read-only, fed by conv_data)
//               Pointer 01 : config register
//               Pointer 10 : Lo_thresh register
//               Pointer 11 : Hi_thresh register
// Ports       : clk, rst      - system clock (>= 20x SCL), sync active-high rst
//               scl_in/sda_in - raw bus lines, asynchronous to clk
//               sda_oe        - 1 = pull SDA low (open-drain)
//               conv_data     - value returned for pointer 00
//               config_reg    - current config register contents
//               config_wr     - one-cycle pulse on a committed config write
//               pointer       - current register pointer
//               busy          - addressed transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ads1115_i2c_target #(
    parameter logic [6:0]  ADDR       = 7'b1001000,
    parameter logic [15:0] CONFIG_RST = 16'h8583,
    parameter logic [15:0] LO_RST     = 16'h8000,
    parameter logic [15:0] HI_RST     = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] conv_data,
    output logic [15:0] config_reg,
    output logic        config_wr,
    output logic [1:0]  pointer,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    state_t      r_state;
    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;
    logic [6:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [1:0]  r_byte_idx;
    logic        r_rw;
    logic        r_rd_byte;     // 0 = MSB in flight, 1 = LSB in flight
    logic        r_mack;        // master acknowledged the last read byte
    logic [15:0] r_tx;
    logic [7:0]  r_hold_msb;
    logic [15:0] r_lo;
    logic [15:0] r_hi;

    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_byte;
    logic [15:0] w_snap;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    // Byte as it stands once the bit on the current rising edge is shifted in.
    assign w_byte     = {r_shift, r_sda_s2};

    always_comb begin
        w_snap = conv_data;
        case (pointer)
            2'b00:   w_snap = conv_data;
            2'b01:   w_snap = config_reg;
            2'b10:   w_snap = r_lo;
            default: w_snap = r_hi;
        endcase
    end

    // Idle bus level is high, so the synchronisers reset to 1 to avoid a
    // phantom START/STOP right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // ACK states share one pattern: the first SCL fall after the 8th bit
    // drives the ACK, the next fall (end of the 9th clock) moves on. sda_oe
    // itself tells the two falls apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            config_wr  <= 1'b0;
            pointer    <= 2'b00;
            config_reg <= CONFIG_RST;
            r_lo       <= LO_RST;
            r_hi       <= HI_RST;
            r_shift    <= 7'd0;
            r_bit_cnt  <= 4'd0;
            r_byte_idx <= 2'd0;
            r_rw       <= 1'b0;
            r_rd_byte  <= 1'b0;
            r_mack     <= 1'b0;
            r_tx       <= 16'd0;
            r_hold_msb <= 8'd0;
        end else begin
            config_wr <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                sda_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (w_byte[7:1] == ADDR) begin
                                r_state <= S_ADDR_ACK;
                                r_rw    <= w_byte[0];
                                busy    <= 1'b1;
                            end else begin
                                r_state <= S_IGNORE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: if (w_scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (r_rw) begin
                            r_tx      <= w_snap;
                            sda_oe    <= ~w_snap[15];
                            r_bit_cnt <= 4'd0;
                            r_rd_byte <= 1'b0;
                            r_state   <= S_RDATA;
                        end else begin
                            sda_oe    <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_PTR;
                        end
                    end
                    S_PTR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (w_byte[7:2] == 6'd0) begin
                                pointer <= w_byte[1:0];
                                r_state <= S_PTR_ACK;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: if (w_scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_WDATA;
                            if (r_state == S_PTR_ACK) r_byte_idx <= 2'd0;
                        end
                    end
                    S_WDATA: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            case (r_byte_idx)
                                2'd0: begin
                                    r_hold_msb <= w_byte;
                                    r_byte_idx <= 2'd1;
                                    r_state    <= S_WDATA_ACK;
                                end
                                2'd1: begin
                                    case (pointer)
                                        2'b01: begin
                                            config_reg <= {r_hold_msb, w_byte};
                                            config_wr  <= 1'b1;
                                        end
                                        2'b10:   r_lo <= {r_hold_msb, w_byte};
                                        2'b11:   r_hi <= {r_hold_msb, w_byte};
                                        default: ;  // conversion register is read-only
                                    endcase
                                    r_byte_idx <= 2'd2;
                                    r_state    <= S_WDATA_ACK;
                                end
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                    end
                    // r_tx[15] is always the bit on the wire; shift on each fall.
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            r_tx <= {r_tx[14:0], 1'b0};
                            if (r_bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                r_state <= S_RDATA_ACK;
                            end else begin
                                sda_oe <= ~r_tx[14];
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= ~r_sda_s2;
                        end else if (w_scl_fall) begin
                            if (r_mack) begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RDATA;
                                if (!r_rd_byte) begin
                                    r_rd_byte <= 1'b1;
                                    sda_oe    <= ~r_tx[15];
                                end else begin
                                    r_tx      <= w_snap;
                                    sda_oe    <= ~w_snap[15];
                                    r_rd_byte <= 1'b0;
                                end
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    default: ;  // S_IDLE, S_IGNORE: wait for START or STOP
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ads1115_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_ads1115_i2c_target
// Description : Bit-banged I2C master driving ads1115_i2c_target, with a
//               register-map reference model built from the ADS1115 rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ads1115_i2c_target;

    localparam int H = 160;  // SCL half period in ns (clk period 10 ns)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic        sda_line;
    logic [15:0] conv_data = 16'h0000;
    logic        sda_oe, config_wr, busy;
    logic [15:0] config_reg;
    logic [1:0]  pointer;

    assign sda_line = ~(m_low | sda_oe);

    ads1115_i2c_target dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .conv_data  (conv_data),
        .config_reg (config_reg),
        .config_wr  (config_wr),
        .pointer    (pointer),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int oe_seen   = 0;
    bit watch_oe  = 1'b0;

    always @(negedge clk) begin
        if (config_wr) wr_pulses++;
        if (watch_oe && sda_oe) oe_seen++;
    end

    // Reference model: register file indexed by pointer, conversion is live.
    logic [15:0] m_reg [4];
    logic [1:0]  m_ptr;

    task automatic model_reset();
        m_reg[0] = 16'h0000;
        m_reg[1] = 16'h8583;
        m_reg[2] = 16'h8000;
        m_reg[3] = 16'h7FFF;
        m_ptr    = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_bit(input bit b, output bit s);
        #(H/2) m_low = ~b;
        #(H/2) scl = 1'b1;
        #(H/2) s = sda_line;
        #(H/2) scl = 1'b0;
    endtask

    task automatic i2c_start();
        #(H/2) m_low = 1'b0;
        #(H/2) scl = 1'b1;
        #(H/2) m_low = 1'b1;
        #(H/2) scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #(H/2) m_low = 1'b1;
        #(H/2) scl = 1'b1;
        #(H/2) m_low = 1'b0;
        #(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input bit mack);
        bit s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            b = {b[6:0], s};
        end
        bus_bit(~mack, s);
    endtask

    // Write transaction: pointer byte plus n data bytes, then STOP.
    task automatic do_write(input logic [7:0] ptr, input int n,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2);
        bit ack, valid;
        int wr0;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        valid = (ptr[7:2] == 6'd0);
        wr0 = wr_pulses;
        i2c_start();
        write_byte(8'h90, ack);
        chk("wr_addr_ack", ack, 1);
        chk("wr_busy", busy, 1);
        write_byte(ptr, ack);
        chk("ptr_ack", ack, valid);
        for (int k = 0; k < n; k++) begin
            write_byte(d[k], ack);
            chk("data_ack", ack, valid && (k < 2));
        end
        i2c_stop();
        if (valid) begin
            m_ptr = ptr[1:0];
            if (n >= 2 && m_ptr != 2'b00) m_reg[m_ptr] = {d0, d1};
        end
        chk("pointer", pointer, m_ptr);
        chk("config_reg", config_reg, m_reg[1]);
        chk("config_wr_pulses", wr_pulses - wr0, (valid && n >= 2 && m_ptr == 2'b01) ? 1 : 0);
        chk("busy_after_stop", busy, 0);
    endtask

    // Read transaction of n bytes, master ACKs all but the last.
    task automatic do_read(input int n);
        bit ack;
        logic [7:0]  b;
        logic [15:0] snap;
        snap = 16'h0000;
        i2c_start();
        write_byte(8'h91, ack);
        chk("rd_addr_ack", ack, 1);
        for (int j = 0; j < n; j++) begin
            if ((j % 2) == 0) snap = (m_ptr == 2'b00) ? conv_data : m_reg[m_ptr];
            read_byte(b, j < n - 1);
            chk("rd_byte", b, (j % 2) ? snap[7:0] : snap[15:8]);
        end
        i2c_stop();
    endtask

    initial begin
        bit ack;
        bit seen;
        logic [7:0]  b;
        logic [15:0] v;
        logic [1:0]  p;

        model_reset();
        #3;
        repeat (5) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_config_wr", config_wr, 0);
        chk("rst_pointer", pointer, 0);
        chk("rst_config_reg", config_reg, 16'h8583);
        rst = 1'b0;
        #(H);

        // Reset value of config read back through pointer 01.
        do_write(8'h01, 0, 8'h00, 8'h00, 8'h00);
        do_read(2);

        // Config write.
        do_write(8'h01, 2, 8'hC4, 8'h83, 8'h00);
        chk("cfg_value", config_reg, 16'hC483);

        // Conversion read with mid-read change of conv_data.
        do_write(8'h00, 0, 8'h00, 8'h00, 8'h00);
        conv_data = 16'h1234;
        i2c_start();
        write_byte(8'h91, ack);
        chk("conv_addr_ack", ack, 1);
        read_byte(b, 1'b1);
        chk("conv_msb", b, 8'h12);
        conv_data = 16'hABCD;
        read_byte(b, 1'b1);
        chk("conv_lsb", b, 8'h34);
        read_byte(b, 1'b0);
        chk("conv_wrap_msb", b, 8'hAB);
        i2c_stop();

        // Address mismatch: target must stay silent.
        oe_seen  = 0;
        watch_oe = 1'b1;
        i2c_start();
        write_byte(8'h92, ack);
        chk("mis_ack", ack, 0);
        chk("mis_busy", busy, 0);
        write_byte(8'h01, ack);
        write_byte(8'h55, ack);
        write_byte(8'h66, ack);
        i2c_stop();
        watch_oe = 1'b0;
        chk("mis_oe_seen", oe_seen, 0);
        chk("mis_config", config_reg, m_reg[1]);
        chk("mis_pointer", pointer, m_ptr);

        // Bad pointer, then overlong write to Lo_thresh.
        do_write(8'h05, 0, 8'h00, 8'h00, 8'h00);
        do_write(8'h02, 3, 8'h11, 8'h22, 8'h33);
        do_read(2);

        // Single data byte then STOP commits nothing; pointer-00 write discarded.
        do_write(8'h03, 1, 8'hAA, 8'h00, 8'h00);
        do_read(2);
        do_write(8'h00, 2, 8'h5A, 8'hA5, 8'h00);
        do_read(2);

        // Randomised register traffic.
        for (int it = 0; it < 5; it++) begin
            p = 2'($urandom_range(1, 3));
            v = 16'($urandom);
            do_write({6'd0, p}, 2, v[15:8], v[7:0], 8'h00);
            do_read(2);
        end
        do_write(8'h00, 0, 8'h00, 8'h00, 8'h00);
        conv_data = 16'($urandom);
        do_read(4);

        // Reset while target drives a 0 bit of the MSB.
        do_write(8'h01, 2, 8'h44, 8'h83, 8'h00);
        i2c_start();
        write_byte(8'h91, ack);
        chk("mid_addr_ack", ack, 1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (sda_oe) seen = 1'b1;
        end
        chk("mid_driving_zero", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sda_oe", sda_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_config", config_reg, 16'h8583);
        chk("mid_rst_pointer", pointer, 0);
        chk("mid_rst_config_wr", config_wr, 0);
        rst = 1'b0;
        model_reset();
        i2c_stop();
        conv_data = 16'($urandom);
        do_read(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
